// File: rtl/vera_video_pkg.sv
// ============================================================================
// Module  : vera_video_pkg
// Purpose : Shared widths and field positions for the palette / video path.
//           Holds the RGB slice within a palette RAM word, the {vsync,hsync}
//           bit order, and the entry layout of the output skid FIFO.
// Ports   : none (package)
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package vera_video_pkg;

  localparam int RGB_W      = 12;
  localparam int PAL_IDX_W  = 8;
  localparam int PAL_DATA_W = 16;

  // RGB occupies the low bits of the palette word; the top nibble is unused.
  localparam int RGB_LSB = 0;
  localparam int RGB_MSB = RGB_LSB + RGB_W - 1;

  // Sync sideband is {vsync,hsync}.
  localparam int SYNC_W         = 2;
  localparam int SYNC_HSYNC_BIT = 0;
  localparam int SYNC_VSYNC_BIT = 1;

  localparam int ENTRY_W = RGB_W + SYNC_W;

  localparam logic [RGB_W-1:0] RGB_BLACK = '0;

  // One output FIFO entry: colour plus its aligned sync bits.
  typedef struct packed {
    logic [RGB_W-1:0]  rgb;
    logic [SYNC_W-1:0] sync;
  } pix_entry_t;

  function automatic logic [RGB_W-1:0] pal_to_rgb(input logic [PAL_DATA_W-1:0] word);
    return word[RGB_MSB:RGB_LSB];
  endfunction

endpackage

`default_nettype wire

// File: rtl/pix_skid_fifo.sv
// ============================================================================
// Module  : pix_skid_fifo
// Purpose : Small synchronous FIFO used as the output skid buffer. Pointers
//           wrap modulo DEPTH, which need not be a power of two.
// Ports   : clk_i        clock
//           rst_i        asynchronous reset, active-high
//           push_i       write push_data_i (ignored only if full and no pop)
//           push_data_i  entry to write
//           pop_i        remove head entry (ignored when empty)
//           count_o      number of stored entries
//           empty_o      no entries stored
//           head_o       oldest entry (undefined while empty)
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module pix_skid_fifo #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 14
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             push_data_i,
  input  logic                         pop_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         empty_o,
  output logic [WIDTH-1:0]             head_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CNT_FULL);
  assign empty_o = (count == '0);
  assign count_o = count;
  assign head_o  = mem[rd_ptr];

  assign do_pop  = pop_i & ~empty_o;
  // A full FIFO can still take a write when the head leaves in the same cycle.
  assign do_push = push_i & (~full | do_pop);

  // Storage needs no reset: entries are only visible through count.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/palette_lookup.sv
// ============================================================================
// Module  : palette_lookup
// Purpose : Converts the composer's 8-bit pixel-index stream into 12-bit RGB
//           via the external 256x16 palette RAM (1-cycle read latency), with
//           the sync sideband kept aligned. A skid FIFO with reserved
//           occupancy guarantees an issued RAM read is never lost.
// Ports   : clk_i          video clock (shared with RAM read port)
//           rst_i          asynchronous reset, active-high
//           pix_valid_i    pixel offered
//           pix_ready_o    pixel accepted this cycle (registered state only)
//           pix_idx_i      palette index
//           pix_blank_i    blanking pixel -> black output
//           pix_border_i   border pixel -> use border_idx_i
//           pix_sync_i     {vsync,hsync} of the pixel
//           border_idx_i   border palette index
//           pal_rd_en_o    palette RAM read enable
//           pal_rd_addr_o  palette RAM read address
//           pal_rd_data_i  palette RAM read data (cycle after pal_rd_en_o)
//           rgb_valid_o    RGB output valid
//           rgb_ready_i    encoder accepts RGB
//           rgb_o          {R,G,B} 4 bits each
//           sync_o         {vsync,hsync} aligned with rgb_o
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module palette_lookup
  import vera_video_pkg::*;
#(
  parameter int                SKID_DEPTH = 3,
  parameter logic [SYNC_W-1:0] SYNC_IDLE  = 2'b00
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  pix_valid_i,
  output logic                  pix_ready_o,
  input  logic [PAL_IDX_W-1:0]  pix_idx_i,
  input  logic                  pix_blank_i,
  input  logic                  pix_border_i,
  input  logic [SYNC_W-1:0]     pix_sync_i,
  input  logic [PAL_IDX_W-1:0]  border_idx_i,
  output logic                  pal_rd_en_o,
  output logic [PAL_IDX_W-1:0]  pal_rd_addr_o,
  input  logic [PAL_DATA_W-1:0] pal_rd_data_i,
  output logic                  rgb_valid_o,
  input  logic                  rgb_ready_i,
  output logic [RGB_W-1:0]      rgb_o,
  output logic [SYNC_W-1:0]     sync_o
);

  localparam int CNT_W = $clog2(SKID_DEPTH + 1);
  localparam logic [CNT_W:0] OCC_LIMIT = (CNT_W + 1)'(SKID_DEPTH);

  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic [ENTRY_W-1:0] fifo_head_bits;
  pix_entry_t        fifo_head;
  pix_entry_t        push_entry;

  logic              accept;
  logic              pop;
  logic [CNT_W:0]    occ;

  // Stage B: sideband of the read currently in flight.
  logic              inflight;
  logic              b_blank;
  logic [SYNC_W-1:0] b_sync;

  // Values shown while the FIFO is empty.
  logic [RGB_W-1:0]  last_rgb;
  logic [SYNC_W-1:0] last_sync;

  // Palette bits above the RGB field carry nothing for this block.
  logic              unused_pal_hi;
  assign unused_pal_hi = ^pal_rd_data_i[PAL_DATA_W-1:RGB_MSB+1];

  // The in-flight read already owns a FIFO slot, so counting it here is what
  // lets stage B push unconditionally. Ready depends only on registers.
  assign occ         = {1'b0, fifo_count} + (CNT_W + 1)'(inflight);
  assign pix_ready_o = (occ < OCC_LIMIT);

  assign accept        = pix_valid_i & pix_ready_o;
  assign pal_rd_en_o   = accept;
  assign pal_rd_addr_o = pix_border_i ? border_idx_i : pix_idx_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inflight <= 1'b0;
      b_blank  <= 1'b0;
      b_sync   <= SYNC_IDLE;
    end else begin
      inflight <= accept;
      if (accept) begin
        b_blank <= pix_blank_i;
        b_sync  <= pix_sync_i;
      end
    end
  end

  // Blank overrides border: the read was still issued, its data is dropped.
  always_comb begin
    push_entry      = '0;
    push_entry.rgb  = b_blank ? RGB_BLACK : pal_to_rgb(pal_rd_data_i);
    push_entry.sync = b_sync;
  end

  assign pop = rgb_valid_o & rgb_ready_i;

  pix_skid_fifo #(
    .DEPTH (SKID_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_skid_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (inflight),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty),
    .head_o      (fifo_head_bits)
  );

  assign fifo_head = fifo_head_bits;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_rgb  <= RGB_BLACK;
      last_sync <= SYNC_IDLE;
    end else if (pop) begin
      last_rgb  <= fifo_head.rgb;
      last_sync <= fifo_head.sync;
    end
  end

  assign rgb_valid_o = ~fifo_empty;
  assign rgb_o       = fifo_empty ? last_rgb  : fifo_head.rgb;
  assign sync_o      = fifo_empty ? last_sync : fifo_head.sync;

endmodule

`default_nettype wire

// File: tb/tb_palette_lookup.sv
// ============================================================================
// Module  : tb_palette_lookup
// Purpose : Directed self-checking bench for palette_lookup with a behavioural
//           palette RAM and an expected-output queue.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_palette_lookup;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        pix_valid_i;
  logic        pix_ready_o;
  logic [7:0]  pix_idx_i;
  logic        pix_blank_i;
  logic        pix_border_i;
  logic [1:0]  pix_sync_i;
  logic [7:0]  border_idx_i;
  logic        pal_rd_en_o;
  logic [7:0]  pal_rd_addr_o;
  logic [15:0] pal_rd_data_i;
  logic        rgb_valid_o;
  logic        rgb_ready_i;
  logic [11:0] rgb_o;
  logic [1:0]  sync_o;

  int errors = 0;
  int checks = 0;
  int pops   = 0;
  int accepts = 0;

  logic [15:0] pal [256];
  logic [13:0] expq [$];

  palette_lookup #(
    .SKID_DEPTH (3),
    .SYNC_IDLE  (2'b00)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .pix_valid_i   (pix_valid_i),
    .pix_ready_o   (pix_ready_o),
    .pix_idx_i     (pix_idx_i),
    .pix_blank_i   (pix_blank_i),
    .pix_border_i  (pix_border_i),
    .pix_sync_i    (pix_sync_i),
    .border_idx_i  (border_idx_i),
    .pal_rd_en_o   (pal_rd_en_o),
    .pal_rd_addr_o (pal_rd_addr_o),
    .pal_rd_data_i (pal_rd_data_i),
    .rgb_valid_o   (rgb_valid_o),
    .rgb_ready_i   (rgb_ready_i),
    .rgb_o         (rgb_o),
    .sync_o        (sync_o)
  );

  always #5 clk_i = ~clk_i;

  // Palette RAM: synchronous read, data valid the cycle after enable.
  always @(posedge clk_i) begin
    if (pal_rd_en_o) pal_rd_data_i <= pal[pal_rd_addr_o];
    else             pal_rd_data_i <= 16'hDEAD;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected FIFO entry for the pixel currently on the inputs.
  function automatic logic [13:0] model_entry();
    logic [7:0]  a;
    logic [15:0] w;
    a = pix_border_i ? border_idx_i : pix_idx_i;
    w = pal[a];
    return {(pix_blank_i ? 12'h000 : w[11:0]), pix_sync_i};
  endfunction

  // Called 2 time units after a rising edge with inputs for the next edge set.
  // Records accepts/pops at that edge, then advances to the next sample point.
  task automatic tick();
    logic [13:0] e;
    #1;
    if (pix_valid_i && pix_ready_o) begin
      accepts++;
      check("rd_addr", {24'd0, pal_rd_addr_o}, {24'd0, (pix_border_i ? border_idx_i : pix_idx_i)});
      check("rd_en", {31'd0, pal_rd_en_o}, 32'd1);
      expq.push_back(model_entry());
    end
    if (rgb_valid_o && rgb_ready_i) begin
      pops++;
      if (expq.size() == 0) begin
        check("pop_unexpected", 32'd1, 32'd0);
      end else begin
        e = expq.pop_front();
        check("pop_entry", {18'd0, rgb_o, sync_o}, {18'd0, e});
      end
    end
    @(posedge clk_i);
    #2;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      logic [7:0] b;
      b = i[7:0];
      pal[i] = {4'hC, b[3:0] ^ 4'h9, b[7:4], b[3:0]};
    end
    pal[3]  = 16'h0AFE;
    pal[14] = 16'h008F;

    rst_i        = 1'b1;
    pix_valid_i  = 1'b0;
    pix_idx_i    = 8'h00;
    pix_blank_i  = 1'b0;
    pix_border_i = 1'b0;
    pix_sync_i   = 2'b00;
    border_idx_i = 8'h0E;
    rgb_ready_i  = 1'b1;

    repeat (3) @(posedge clk_i);
    #2;
    rst_i = 1'b0;
    #1;
    check("rst_ready", {31'd0, pix_ready_o}, 32'd1);
    check("rst_valid", {31'd0, rgb_valid_o}, 32'd0);
    check("rst_rgb",   {20'd0, rgb_o},       32'h000);
    check("rst_sync",  {30'd0, sync_o},      32'd0);
    check("rst_rd_en", {31'd0, pal_rd_en_o}, 32'd0);
    @(posedge clk_i);
    #2;

    // 1: single pixel, latency of two cycles.
    pix_valid_i = 1'b1;
    pix_idx_i   = 8'h03;
    tick();
    pix_valid_i = 1'b0;
    check("t1_valid_n1", {31'd0, rgb_valid_o}, 32'd0);
    tick();
    check("t1_valid_n2", {31'd0, rgb_valid_o}, 32'd1);
    check("t1_rgb",      {20'd0, rgb_o},       32'hAFE);
    tick();
    check("t1_empty", {31'd0, rgb_valid_o}, 32'd0);
    check("t1_hold",  {20'd0, rgb_o},       32'hAFE);

    // 2: stream all indices with the sink always ready.
    pops = 0;
    for (int i = 0; i < 256; i++) begin
      pix_valid_i = 1'b1;
      pix_idx_i   = i[7:0];
      check("t2_ready", {31'd0, pix_ready_o}, 32'd1);
      tick();
    end
    pix_valid_i = 1'b0;
    tick();
    tick();
    check("t2_pops", pops, 32'd256);
    check("t2_drained", expq.size(), 32'd0);

    // 3: sink stalled, exactly SKID_DEPTH accepted.
    rgb_ready_i = 1'b0;
    accepts = 0;
    for (int k = 0; k < 8; k++) begin
      pix_valid_i = 1'b1;
      pix_idx_i   = 8'h10 + k[7:0];
      pix_sync_i  = k[1:0];
      tick();
    end
    check("t3_accepts", accepts, 32'd3);
    check("t3_ready_low", {31'd0, pix_ready_o}, 32'd0);
    check("t3_valid", {31'd0, rgb_valid_o}, 32'd1);
    rgb_ready_i = 1'b1;
    #1;
    check("t3_ready_same_cycle", {31'd0, pix_ready_o}, 32'd0);
    pix_valid_i = 1'b0;
    repeat (6) tick();
    check("t3_drained", expq.size(), 32'd0);
    check("t3_rgb_last", {20'd0, rgb_o}, {20'd0, pal[8'h12][11:0]});
    pix_sync_i = 2'b00;

    // 4: border lookup, then blank overriding border.
    pix_valid_i  = 1'b1;
    pix_border_i = 1'b1;
    pix_idx_i    = 8'h55;
    tick();
    pix_valid_i = 1'b0;
    tick();
    check("t4_border_rgb", {20'd0, rgb_o}, 32'h08F);
    tick();
    pix_valid_i = 1'b1;
    pix_blank_i = 1'b1;
    tick();
    pix_valid_i = 1'b0;
    tick();
    check("t4_blank_rgb", {20'd0, rgb_o}, 32'h000);
    check("t4_blank_valid", {31'd0, rgb_valid_o}, 32'd1);
    tick();
    pix_blank_i  = 1'b0;
    pix_border_i = 1'b0;

    // 5: sync pattern with a randomly stalling sink.
    for (int k = 0; k < 40; k++) begin
      logic [1:0] pat [4];
      pat[0] = 2'b00; pat[1] = 2'b01; pat[2] = 2'b11; pat[3] = 2'b10;
      pix_valid_i = 1'b1;
      pix_idx_i   = 8'h40 + k[7:0];
      pix_sync_i  = pat[k % 4];
      rgb_ready_i = 1'($urandom_range(0, 1));
      tick();
    end
    pix_valid_i = 1'b0;
    rgb_ready_i = 1'b1;
    repeat (6) tick();
    check("t5_drained", expq.size(), 32'd0);

    // 6: reset with FIFO full-ish and a read in flight.
    rgb_ready_i = 1'b0;
    pix_sync_i  = 2'b11;
    accepts = 0;
    for (int k = 0; k < 3; k++) begin
      pix_valid_i = 1'b1;
      pix_idx_i   = 8'h20 + k[7:0];
      tick();
    end
    check("t6_accepts", accepts, 32'd3);
    check("t6_pre_valid", {31'd0, rgb_valid_o}, 32'd1);
    pix_valid_i = 1'b0;
    rst_i = 1'b1;
    #1;
    check("t6_rst_valid", {31'd0, rgb_valid_o}, 32'd0);
    check("t6_rst_rgb",   {20'd0, rgb_o},       32'h000);
    check("t6_rst_sync",  {30'd0, sync_o},      32'd0);
    check("t6_rst_ready", {31'd0, pix_ready_o}, 32'd1);
    expq.delete();
    @(posedge clk_i);
    #2;
    rst_i = 1'b0;
    rgb_ready_i = 1'b1;
    pix_valid_i = 1'b1;
    pix_idx_i   = 8'h03;
    pix_sync_i  = 2'b01;
    tick();
    pix_valid_i = 1'b0;
    check("t6_no_stale", {31'd0, rgb_valid_o}, 32'd0);
    tick();
    check("t6_first_rgb",  {20'd0, rgb_o},  32'hAFE);
    check("t6_first_sync", {30'd0, sync_o}, 32'd1);
    tick();
    tick();
    check("t6_empty_after", {31'd0, rgb_valid_o}, 32'd0);
    check("t6_drained", expq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
